pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-sequencing controller for the Pong datapath. It sits between the debounced buttons, the pixel generator and the score display. It consumes per-frame ticks and ball hit/miss events from the pixel generator and runs the new-game / play / new-ball / game-over sequence. It drives the pixel generator's ball hold/run controls and text overlay select, and keeps the BCD score and remaining lives for the seven-segment driver.

## Interface
- TIMER_FRAMES, 120: refresh ticks spent in NEWBALL and the minimum time in OVER (2 s at 60 Hz).
- LIVES, 3: balls per game, range 1..3.

- clk_100MHz  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- refresh_tick  in  1  one-cycle pulse per frame from the pixel generator.
- btn_start  in  1  debounced level; OR of up/down buttons.
- hit  in  1  one-cycle pulse: ball struck paddle.
- miss  in  1  one-cycle pulse: ball passed paddle.
- ball_reset  out  1  hold ball at screen centre.
- ball_run  out  1  enable ball motion.
- text_sel  out  2  overlay: 00 none, 01 start prompt, 10 game over.
- score  out  16  four BCD digits, [15:12] thousands.
- lives  out  2  balls remaining.
- state  out  2  current state, for debug: 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.

## Operation
- Start edge: start_rise = btn_start & ~btn_q. btn_q is registered every cycle and resets to 1, so a button held through reset must be released before it counts.
- NEWGAME:
  - Outputs: ball_reset=1, ball_run=0, text_sel=01.
  - start_rise -> PLAY.
- PLAY:
  - Outputs: ball_reset=0, ball_run=1, text_sel=00.
  - hit: score increments in BCD with per-digit carry (9 -> 0, carry to next digit). The score saturates at 9999; a hit at 9999 leaves it unchanged.
  - miss with lives>1: lives decrements, timer loads TIMER_FRAMES, go to NEWBALL.
  - miss with lives==1: lives becomes 0, timer loads TIMER_FRAMES, go to OVER.
  - hit and miss in the same cycle: miss takes effect, hit is discarded, score unchanged.
- NEWBALL:
  - Outputs: ball_reset=1, ball_run=0, text_sel=00.
  - The timer decrements on each refresh_tick while nonzero. Timer==0 -> PLAY.
  - btn_start is ignored.
- OVER:
  - Outputs: ball_reset=1, ball_run=0, text_sel=10.
  - The timer decrements on refresh_tick as in NEWBALL.
  - start_rise while timer==0 -> NEWGAME, with score cleared to 0x0000 and lives reloaded to LIVES on that transition.
  - A start_rise while timer>0 is ignored.
- hit and miss are ignored outside PLAY. refresh_tick has no effect except on the timer.
- Timer width: $clog2(TIMER_FRAMES+1) bits, unsigned, never wraps below 0.

## Timing
- Reset values: state=NEWGAME, score=0x0000, lives=LIVES, timer=0, btn_q=1, ball_reset=1, ball_run=0, text_sel=01.
- All outputs are registered, with no combinational input-to-output path.
- State transitions and the matching output changes occur on the clock edge after the triggering input cycle (1-cycle latency).
- score and lives update on the same edge as the associated transition.
- NEWBALL lasts exactly TIMER_FRAMES refresh ticks plus 1 cycle. PLAY is entered on the edge after the tick that brings the timer to 0.
- refresh_tick coincident with the state-entry edge does not decrement: the load wins.
- Reset asserted mid-game returns to the reset values asynchronously. Release is synchronous to the next edge.

## Test plan
- Reset with btn_start held high, then release and press:
  - While held: state stays NEWGAME, text_sel=01.
  - After the press: PLAY 1 cycle later, ball_run=1, ball_reset=0.
- In PLAY, 12 hit pulses -> score=0x0012. Preload score 0x0999 and hit -> 0x1000. Score 0x9999 and hit -> stays 0x9999.
- In PLAY with lives=3, miss:
  - Immediately: lives=2, state NEWBALL, ball_reset=1.
  - After 120 refresh ticks (TIMER_FRAMES=120): PLAY, with no button press needed.
- Three misses -> lives=0, state OVER, text_sel=10. Then:
  - start_rise before 120 ticks is ignored.
  - start_rise after expiry -> NEWGAME, score=0x0000, lives=3.
- hit and miss in the same cycle with score 0x0005, lives=2 -> score 0x0005, lives=1, NEWBALL.
- hit/miss pulses during NEWGAME, NEWBALL and OVER -> score, lives and state unchanged.
- Assert reset_n low mid-PLAY between clock edges -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new-game / play / new-ball / game-over flow, BCD score and lives.
// All outputs are registered; the overlay and ball controls are decoded from the next state.
`timescale 1ns/1ps
module pong_game_ctrl #(
   parameter int unsigned TIMER_FRAMES = 120,
   parameter int unsigned LIVES        = 3
) (
   input  logic        clk_100MHz,
   input  logic        reset_n,
   input  logic        refresh_tick,
   input  logic        btn_start,
   input  logic        hit,
   input  logic        miss,
   output logic        ball_reset,
   output logic        ball_run,
   output logic [1:0]  text_sel,
   output logic [15:0] score,
   output logic [1:0]  lives,
   output logic [1:0]  state
);

   localparam int unsigned TimerW = $clog2(TIMER_FRAMES + 1);
   localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMER_FRAMES);
   localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
   localparam logic [1:0]        LivesInit = 2'(LIVES);

   typedef enum logic [1:0] {
      StNewGame = 2'b00,
      StPlay    = 2'b01,
      StNewBall = 2'b10,
      StOver    = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [15:0]         score_q, score_d;
   logic [1:0]          lives_q, lives_d;
   logic [TimerW-1:0]   timer_q, timer_d, timer_dec;
   logic                btn_q;
   logic                start_rise;

   // Saturating four-digit BCD increment.
   function automatic logic [15:0] bcd_inc(input logic [15:0] s);
      logic [15:0] r;
      logic        carry;
      r     = s;
      carry = 1'b1;
      if (s != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[4*i +: 4] == 4'd9) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   assign start_rise = btn_start & ~btn_q;
   assign timer_dec  = (refresh_tick && timer_q != '0) ? timer_q - TimerOne : timer_q;

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      lives_d = lives_q;
      timer_d = timer_q;
      case (state_q)
         StNewGame: begin
            if (start_rise) state_d = StPlay;
         end
         StPlay: begin
            if (miss) begin
               timer_d = TimerLoad;
               if (lives_q > 2'd1) begin
                  lives_d = lives_q - 2'd1;
                  state_d = StNewBall;
               end else begin
                  lives_d = 2'd0;
                  state_d = StOver;
               end
            end else if (hit) begin
               score_d = bcd_inc(score_q);
            end
         end
         StNewBall: begin
            if (timer_q == '0) state_d = StPlay;
            else               timer_d = timer_dec;
         end
         StOver: begin
            if (timer_q != '0) begin
               timer_d = timer_dec;
            end else if (start_rise) begin
               state_d = StNewGame;
               score_d = 16'h0000;
               lives_d = LivesInit;
            end
         end
         default: state_d = StNewGame;
      endcase
   end

   // btn_q resets high so a button held through reset must be released first.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StNewGame;
         score_q    <= 16'h0000;
         lives_q    <= LivesInit;
         timer_q    <= '0;
         btn_q      <= 1'b1;
         ball_reset <= 1'b1;
         ball_run   <= 1'b0;
         text_sel   <= 2'b01;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         lives_q <= lives_d;
         timer_q <= timer_d;
         btn_q   <= btn_start;
         case (state_d)
            StNewGame: begin
               ball_reset <= 1'b1;
               ball_run   <= 1'b0;
               text_sel   <= 2'b01;
            end
            StPlay: begin
               ball_reset <= 1'b0;
               ball_run   <= 1'b1;
               text_sel   <= 2'b00;
            end
            StNewBall: begin
               ball_reset <= 1'b1;
               ball_run   <= 1'b0;
               text_sel   <= 2'b00;
            end
            default: begin
               ball_reset <= 1'b1;
               ball_run   <= 1'b0;
               text_sel   <= 2'b10;
            end
         endcase
      end
   end

   assign state = state_q;
   assign score = score_q;
   assign lives = lives_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

   logic        clk_100MHz = 1'b0;
   logic        reset_n;
   logic        refresh_tick;
   logic        btn_start;
   logic        hit;
   logic        miss;
   logic        ball_reset;
   logic        ball_run;
   logic [1:0]  text_sel;
   logic [15:0] score;
   logic [1:0]  lives;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   pong_game_ctrl #(
      .TIMER_FRAMES(120),
      .LIVES       (3)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .reset_n     (reset_n),
      .refresh_tick(refresh_tick),
      .btn_start   (btn_start),
      .hit         (hit),
      .miss        (miss),
      .ball_reset  (ball_reset),
      .ball_run    (ball_run),
      .text_sel    (text_sel),
      .score       (score),
      .lives       (lives),
      .state       (state)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic pulse_hits(input int n);
      hit = 1'b1;
      repeat (n) step();
      hit = 1'b0;
   endtask

   task automatic pulse_miss();
      miss = 1'b1;
      step();
      miss = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         refresh_tick = 1'b1;
         step();
         refresh_tick = 1'b0;
         step();
      end
   endtask

   task automatic press();
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      step();
   endtask

   initial begin
      reset_n      = 1'b0;
      refresh_tick = 1'b0;
      btn_start    = 1'b1;
      hit          = 1'b0;
      miss         = 1'b0;
      repeat (3) step();
      check_eq("rst_state", state, 2'b00);
      check_eq("rst_score", score, 16'h0000);
      check_eq("rst_lives", lives, 2'd3);
      check_eq("rst_ball_reset", ball_reset, 1'b1);
      check_eq("rst_ball_run", ball_run, 1'b0);
      check_eq("rst_text", text_sel, 2'b01);

      // Button held through reset must not start the game.
      reset_n = 1'b1;
      repeat (5) step();
      check_eq("held_state", state, 2'b00);
      check_eq("held_text", text_sel, 2'b01);
      btn_start = 1'b0;
      step();
      check_eq("release_state", state, 2'b00);
      btn_start = 1'b1;
      step();
      check_eq("start_state", state, 2'b01);
      check_eq("start_run", ball_run, 1'b1);
      check_eq("start_reset", ball_reset, 1'b0);
      check_eq("start_text", text_sel, 2'b00);
      btn_start = 1'b0;

      pulse_hits(12);
      check_eq("score_12", score, 16'h0012);
      pulse_hits(987);
      check_eq("score_999", score, 16'h0999);
      pulse_hits(1);
      check_eq("score_1000", score, 16'h1000);
      pulse_hits(8999);
      check_eq("score_9999", score, 16'h9999);
      pulse_hits(1);
      check_eq("score_sat", score, 16'h9999);

      pulse_miss();
      check_eq("miss1_lives", lives, 2'd2);
      check_eq("miss1_state", state, 2'b10);
      check_eq("miss1_reset", ball_reset, 1'b1);
      check_eq("miss1_run", ball_run, 1'b0);
      check_eq("miss1_text", text_sel, 2'b00);

      pulse_hits(1);
      pulse_miss();
      press();
      check_eq("nb_ign_score", score, 16'h9999);
      check_eq("nb_ign_lives", lives, 2'd2);
      check_eq("nb_ign_state", state, 2'b10);

      ticks(119);
      check_eq("nb_119_state", state, 2'b10);
      refresh_tick = 1'b1;
      step();
      refresh_tick = 1'b0;
      check_eq("nb_120_state", state, 2'b10);
      step();
      check_eq("nb_exit_state", state, 2'b01);
      check_eq("nb_exit_run", ball_run, 1'b1);

      pulse_miss();
      check_eq("miss2_lives", lives, 2'd1);
      check_eq("miss2_state", state, 2'b10);
      ticks(120);
      step();
      check_eq("miss2_play", state, 2'b01);

      pulse_miss();
      check_eq("over_lives", lives, 2'd0);
      check_eq("over_state", state, 2'b11);
      check_eq("over_text", text_sel, 2'b10);
      check_eq("over_reset", ball_reset, 1'b1);

      pulse_hits(1);
      pulse_miss();
      check_eq("over_ign_score", score, 16'h9999);
      check_eq("over_ign_lives", lives, 2'd0);
      check_eq("over_ign_state", state, 2'b11);

      press();
      check_eq("over_early", state, 2'b11);
      ticks(119);
      press();
      check_eq("over_timer1", state, 2'b11);
      ticks(1);
      check_eq("over_expired", state, 2'b11);
      btn_start = 1'b1;
      step();
      check_eq("ng_state", state, 2'b00);
      check_eq("ng_score", score, 16'h0000);
      check_eq("ng_lives", lives, 2'd3);
      check_eq("ng_text", text_sel, 2'b01);
      btn_start = 1'b0;
      step();

      pulse_hits(1);
      pulse_miss();
      check_eq("ng_ign_state", state, 2'b00);
      check_eq("ng_ign_score", score, 16'h0000);
      check_eq("ng_ign_lives", lives, 2'd3);

      btn_start = 1'b1;
      step();
      check_eq("g2_state", state, 2'b01);
      btn_start = 1'b0;
      pulse_hits(5);
      check_eq("g2_score", score, 16'h0005);
      pulse_miss();
      check_eq("g2_lives", lives, 2'd2);
      ticks(120);
      step();
      check_eq("g2_play", state, 2'b01);

      hit  = 1'b1;
      miss = 1'b1;
      step();
      hit  = 1'b0;
      miss = 1'b0;
      check_eq("hm_score", score, 16'h0005);
      check_eq("hm_lives", lives, 2'd1);
      check_eq("hm_state", state, 2'b10);
      ticks(120);
      step();
      check_eq("hm_play", state, 2'b01);

      // Asynchronous reset between edges.
      @(posedge clk_100MHz);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_state", state, 2'b00);
      check_eq("arst_score", score, 16'h0000);
      check_eq("arst_lives", lives, 2'd3);
      check_eq("arst_reset", ball_reset, 1'b1);
      check_eq("arst_run", ball_run, 1'b0);
      check_eq("arst_text", text_sel, 2'b01);
      step();
      reset_n = 1'b1;
      step();
      check_eq("arst_after", state, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
